// File: rtl/capture_lock_if.sv
// Capture-lock bundle: frontend timing measurements in, scanconverter enable and
// lock status out. The frontend/testbench side uses master, the controller uses slave.
interface capture_lock_if;
    logic        sync_active_i;
    logic        frame_change_i;
    logic [10:0] vtotal_i;
    logic        interlace_i;
    logic        relock_req_i;
    logic        sc_enable_o;
    logic [1:0]  lock_state_o;
    logic        resync_toggle_o;
    logic [7:0]  lost_cnt_o;

    modport master (
        output sync_active_i, frame_change_i, vtotal_i, interlace_i, relock_req_i,
        input  sc_enable_o, lock_state_o, resync_toggle_o, lost_cnt_o
    );

    modport slave (
        input  sync_active_i, frame_change_i, vtotal_i, interlace_i, relock_req_i,
        output sc_enable_o, lock_state_o, resync_toggle_o, lost_cnt_o
    );
endinterface

// File: rtl/capture_lock_ctrl.sv
// Qualifies input timing (sync, vtotal, interlace) before enabling the scanconverter.
// Optional CAPTURE_LOCK_STATS_EN adds the saturating loss-of-lock counter on lost_cnt_o.
module capture_lock_ctrl #(
    parameter int unsigned LOCK_FRAMES    = 3,
    parameter int unsigned VTOTAL_TOL     = 1,
    parameter int unsigned FRAME_TIMEOUT  = 2097151,
    parameter int unsigned HOLDOFF_CYCLES = 65535
) (
    input  logic           TVP_PCLK_i,
    input  logic           po_reset_n,
    capture_lock_if.slave  bus
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF = 2'd3;

    localparam logic [3:0]  LOCK_N    = 4'(LOCK_FRAMES);
    localparam logic [11:0] TOL       = 12'(VTOTAL_TOL);
    localparam logic [20:0] TMO_LIMIT = 21'(FRAME_TIMEOUT);
    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [10:0] ref_vtotal_q, ref_vtotal_d;
    logic        ref_il_q, ref_il_d;
    logic        ref_vld_q, ref_vld_d;
    logic [3:0]  stable_q, stable_d;
    logic [20:0] tmo_q, tmo_d;
    logic [15:0] hold_q, hold_d;
    logic        sc_en_q;
    logic        toggle_q, toggle_d;
    logic [2:0]  relock_q;
    logic        lost_evt;

    // [0],[1] are the synchronizer stages, [2] is the previous synced level
    logic relock_edge;
    assign relock_edge = relock_q[1] & ~relock_q[2];

    logic [11:0] vt_a, vt_b, vt_diff;
    logic        frame_match, tmo_hit;
    assign vt_a        = {1'b0, bus.vtotal_i};
    assign vt_b        = {1'b0, ref_vtotal_q};
    assign vt_diff     = (vt_a >= vt_b) ? (vt_a - vt_b) : (vt_b - vt_a);
    assign frame_match = (vt_diff <= TOL) && (bus.interlace_i == ref_il_q);
    assign tmo_hit     = (tmo_q >= TMO_LIMIT);

    always_comb begin
        state_d      = state_q;
        ref_vtotal_d = ref_vtotal_q;
        ref_il_d     = ref_il_q;
        ref_vld_d    = ref_vld_q;
        stable_d     = stable_q;
        hold_d       = hold_q;
        tmo_d        = tmo_q;
        lost_evt     = 1'b0;

        if ((state_q == ST_ACQUIRE || state_q == ST_LOCKED) && tmo_q != '1)
            tmo_d = tmo_q + 21'd1;

        case (state_q)
            ST_IDLE: begin
                if (bus.sync_active_i) begin
                    state_d   = ST_ACQUIRE;
                    ref_vld_d = 1'b0;
                    stable_d  = 4'd0;
                end
            end
            ST_ACQUIRE: begin
                if (!bus.sync_active_i) begin
                    state_d = ST_IDLE;
                end else if (bus.frame_change_i) begin
                    tmo_d = '0;
                    if (ref_vld_q && frame_match) begin
                        stable_d = stable_q + 4'd1;
                        if (stable_q + 4'd1 == LOCK_N)
                            state_d = ST_LOCKED;
                    end else begin
                        ref_vtotal_d = bus.vtotal_i;
                        ref_il_d     = bus.interlace_i;
                        ref_vld_d    = 1'b1;
                        stable_d     = 4'd0;
                    end
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (!bus.sync_active_i || (bus.frame_change_i && !frame_match) ||
                    (!bus.frame_change_i && tmo_hit)) begin
                    state_d  = ST_HOLDOFF;
                    hold_d   = 16'd0;
                    lost_evt = 1'b1;
                end else if (bus.frame_change_i) begin
                    tmo_d = '0;
                end
            end
            default: begin
                if (hold_q == HOLD_LAST)
                    state_d = ST_IDLE;
                else
                    hold_d = hold_q + 16'd1;
            end
        endcase

        // CPU relock overrides everything, including a loss detected this cycle
        if (relock_edge) begin
            state_d  = ST_HOLDOFF;
            hold_d   = 16'd0;
            lost_evt = 1'b0;
        end

        if (state_d != state_q)
            tmo_d = '0;
    end

    assign toggle_d = toggle_q ^ lost_evt;

    always_ff @(posedge TVP_PCLK_i or negedge po_reset_n) begin
        if (!po_reset_n) begin
            state_q      <= ST_IDLE;
            ref_vtotal_q <= '0;
            ref_il_q     <= 1'b0;
            ref_vld_q    <= 1'b0;
            stable_q     <= '0;
            tmo_q        <= '0;
            hold_q       <= '0;
            sc_en_q      <= 1'b0;
            toggle_q     <= 1'b0;
            relock_q     <= '0;
        end else begin
            state_q      <= state_d;
            ref_vtotal_q <= ref_vtotal_d;
            ref_il_q     <= ref_il_d;
            ref_vld_q    <= ref_vld_d;
            stable_q     <= stable_d;
            tmo_q        <= tmo_d;
            hold_q       <= hold_d;
            sc_en_q      <= (state_d == ST_LOCKED);
            toggle_q     <= toggle_d;
            relock_q     <= {relock_q[1:0], bus.relock_req_i};
        end
    end

`ifdef CAPTURE_LOCK_STATS_EN
    logic [7:0] lost_q;
    always_ff @(posedge TVP_PCLK_i or negedge po_reset_n) begin
        if (!po_reset_n)
            lost_q <= '0;
        else if (lost_evt && lost_q != 8'hFF)
            lost_q <= lost_q + 8'd1;
    end
    assign bus.lost_cnt_o = lost_q;
`else
    assign bus.lost_cnt_o = 8'h00;
`endif

    assign bus.sc_enable_o     = sc_en_q;
    assign bus.lock_state_o    = state_q;
    assign bus.resync_toggle_o = toggle_q;

endmodule

// File: tb/tb_capture_lock_ctrl.sv
// Scoreboarded bench for capture_lock_ctrl: a rule-level model predicts the outputs
// after every clock; a monitor compares them one edge later.
module tb_capture_lock_ctrl;
    localparam int LF = 3;
    localparam int TOL = 1;
    localparam int FT = 40;
    localparam int HC = 20;
    localparam int S_IDLE = 0, S_ACQ = 1, S_LCK = 2, S_HOLD = 3;
`ifdef CAPTURE_LOCK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic po_reset_n = 1'b0;
    always #5 clk = ~clk;

    capture_lock_if bus();

    capture_lock_ctrl #(
        .LOCK_FRAMES(LF), .VTOTAL_TOL(TOL), .FRAME_TIMEOUT(FT), .HOLDOFF_CYCLES(HC)
    ) dut (
        .TVP_PCLK_i (clk),
        .po_reset_n (po_reset_n),
        .bus        (bus.slave)
    );

    typedef struct packed {
        logic [1:0] st;
        logic       en;
        logic       tog;
        logic [7:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // model of the specified behaviour
    int m_state, m_ref, m_since, m_matches, m_hold_left, m_lost;
    bit m_ref_il, m_ref_ok, m_tog;
    bit rlh[3];

    task automatic model_reset();
        m_state = S_IDLE; m_ref = 0; m_since = 0; m_matches = 0; m_hold_left = 0;
        m_lost = 0; m_ref_il = 0; m_ref_ok = 0; m_tog = 0;
        rlh[0] = 0; rlh[1] = 0; rlh[2] = 0;
    endtask

    function automatic bit fits(int vt, bit il);
        int d = vt - m_ref;
        if (d < 0) d = -d;
        return (d <= TOL) && (il == m_ref_il);
    endfunction

    task automatic model_step(input bit sa, input bit fc, input int vt, input bit il, input bit rl);
        bit rl_edge = rlh[1] && !rlh[2];
        bit m = fits(vt, il);
        rlh[2] = rlh[1]; rlh[1] = rlh[0]; rlh[0] = rl;
        if (rl_edge) begin
            m_state = S_HOLD; m_hold_left = HC;
        end else begin
            case (m_state)
                S_IDLE: if (sa) begin
                    m_state = S_ACQ; m_ref_ok = 0; m_matches = 0; m_since = 0;
                end
                S_ACQ: begin
                    if (!sa) m_state = S_IDLE;
                    else if (fc) begin
                        m_since = 0;
                        if (m_ref_ok && m) begin
                            m_matches++;
                            if (m_matches == LF) m_state = S_LCK;
                        end else begin
                            m_ref = vt; m_ref_il = il; m_ref_ok = 1; m_matches = 0;
                        end
                    end else if (m_since >= FT) m_state = S_IDLE;
                    else m_since++;
                end
                S_LCK: begin
                    if (!sa || (fc && !m) || (!fc && m_since >= FT)) begin
                        m_state = S_HOLD; m_hold_left = HC; m_tog = !m_tog;
                        if (m_lost < 255) m_lost++;
                    end else if (fc) m_since = 0;
                    else m_since++;
                end
                default: begin
                    if (m_hold_left == 1) m_state = S_IDLE;
                    else m_hold_left--;
                end
            endcase
        end
    endtask

    task automatic cyc(input bit sa, input bit fc, input int vt, input bit il, input bit rl);
        exp_t e;
        @(negedge clk);
        bus.sync_active_i  = sa;
        bus.frame_change_i = fc;
        bus.vtotal_i       = 11'(vt);
        bus.interlace_i    = il;
        bus.relock_req_i   = rl;
        model_step(sa, fc, vt, il, rl);
        e.st  = 2'(m_state);
        e.en  = (m_state == S_LCK);
        e.tog = m_tog;
        e.cnt = STATS ? 8'(m_lost) : 8'h00;
        expq.push_back(e);
    endtask

    task automatic idle(input int n, input bit sa);
        repeat (n) cyc(sa, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic frame(input int vt, input bit il, input int gap);
        idle(gap - 1, 1'b1);
        cyc(1'b1, 1'b1, vt, il, 1'b0);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_state != S_IDLE && n < 200) begin
            cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
            n++;
        end
        n_chk++;
        if (m_state != S_IDLE) begin
            n_fail++;
            $display("FAIL wait_idle: model state %0d, required %0d within 200 cycles", m_state, S_IDLE);
        end
    endtask

    task automatic lock_up(input int vt, input int gap);
        wait_idle();
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        repeat (LF + 1) frame(vt, 1'b0, gap);
    endtask

    task automatic check_zero(input string name);
        n_chk++;
        if (bus.sc_enable_o !== 1'b0 || bus.lock_state_o !== 2'd0 ||
            bus.resync_toggle_o !== 1'b0 || bus.lost_cnt_o !== 8'h00) begin
            n_fail++;
            $display("FAIL %s: actual en=%b st=%0d tog=%b cnt=%0d, required all zero", name,
                     bus.sc_enable_o, bus.lock_state_o, bus.resync_toggle_o, bus.lost_cnt_o);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        po_reset_n = 1'b0;
        bus.sync_active_i = 0; bus.frame_change_i = 0; bus.vtotal_i = '0;
        bus.interlace_i = 0; bus.relock_req_i = 0;
        #1 check_zero("reset_async");
        repeat (3) @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        po_reset_n = 1'b1;
        model_reset();
    endtask

    // monitor: one comparison per clock while predictions are pending
    initial begin
        exp_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a = {bus.lock_state_o, bus.sc_enable_o, bus.resync_toggle_o, bus.lost_cnt_o};
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: actual st=%0d en=%b tog=%b cnt=%0d, required st=%0d en=%b tog=%b cnt=%0d",
                             $time, a.st, a.en, a.tog, a.cnt, e.st, e.en, e.tog, e.cnt);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rl;
        bus.sync_active_i = 0; bus.frame_change_i = 0; bus.vtotal_i = '0;
        bus.interlace_i = 0; bus.relock_req_i = 0;
        model_reset();
        #1 check_zero("reset_initial");
        do_reset();

        // acquire on 262 lines, tolerate 263, lose on 525
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) frame(262, 1'b0, 6);
        frame(263, 1'b0, 6);
        frame(525, 1'b0, 6);
        wait_idle();

        // reference reload on mismatch
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        frame(262, 1'b0, 5); frame(262, 1'b0, 5);
        repeat (4) frame(300, 1'b0, 5);
        // interlace flip while locked is a mismatch
        frame(300, 1'b1, 5);

        // frame timeout while locked, then frame landing exactly on the timeout cycle
        lock_up(262, 4);
        idle(FT + 3, 1'b1);
        lock_up(262, 4);
        while (m_since < FT) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 262, 1'b0, 1'b0);
        idle(5, 1'b1);

        // sync loss coincident with a good frame
        cyc(1'b0, 1'b1, 262, 1'b0, 1'b0);
        wait_idle();

        // relock while locked, and again mid-holdoff to restart it
        lock_up(262, 4);
        repeat (6) cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
        repeat (8) cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) cyc(1'b1, 1'b0, 0, 1'b0, 1'b1);
        wait_idle();

        // randomized traffic
        rl = 0;
        for (int i = 0; i < 4000; i++) begin
            int vt;
            case ($urandom_range(0, 7))
                0, 1, 2, 3: vt = 262;
                4: vt = 263;
                5: vt = 261;
                6: vt = 264;
                default: vt = int'($urandom_range(0, 2047));
            endcase
            if ($urandom_range(0, 299) == 0) rl = !rl;
            cyc($urandom_range(0, 99) < 97, $urandom_range(0, 7) == 0, vt,
                $urandom_range(0, 15) == 0, rl);
        end
        idle(4, 1'b0);
        wait_idle();

        // asynchronous reset while locked
        lock_up(262, 3);
        do_reset();

        // force enough losses to saturate the counter
        for (int k = 0; k < 260; k++) begin
            lock_up(262, 2);
            cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
        end
        wait_idle();
        @(posedge clk);
        #2;
        n_chk++;
        if (bus.lost_cnt_o !== (STATS ? 8'd255 : 8'd0)) begin
            n_fail++;
            $display("FAIL lost_cnt_sat: actual %0d, required %0d", bus.lost_cnt_o, STATS ? 255 : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/capture_lock_ctrl.md
# capture_lock_ctrl

Sequencer in the TVP_PCLK_i domain that qualifies the frontend's measured input timing before the scanconverter is allowed to run. It watches sync presence, per-frame vtotal and interlace flag, and only enables the scanconverter after a run of consistent frames. On a loss of lock it drops the enable, holds off, and signals a resync event to the clk27 side.

## Interface
Parameters:
- LOCK_FRAMES, 3: consecutive matching frames required to enter LOCKED (1..15).
- VTOTAL_TOL, 1: allowed |vtotal − reference| in lines.
- FRAME_TIMEOUT, 2097151: pixel clocks without frame_change_i before declaring loss (fits 21 bits).
- HOLDOFF_CYCLES, 65535: cycles sc_enable_o stays low in HOLDOFF (fits 16 bits).

Ports:
- TVP_PCLK_i  in  1  capture pixel clock.
- po_reset_n  in  1  reset, asynchronous, active-low.
- sync_active_i  in  1  frontend sync-present level.
- frame_change_i  in  1  one-cycle pulse at each frame start.
- vtotal_i  in  11  measured lines/frame, valid when frame_change_i=1.
- interlace_i  in  1  interlace flag, valid when frame_change_i=1.
- relock_req_i  in  1  CPU relock request level (clk27 domain, async here).
- sc_enable_o  out  1  scanconverter/line-buffer enable.
- lock_state_o  out  2  0 IDLE, 1 ACQUIRE, 2 LOCKED, 3 HOLDOFF.
- resync_toggle_o  out  1  toggles once per loss-of-lock event.
- lost_cnt_o  out  8  saturating count of loss-of-lock events.

## Operation
- Reset: state IDLE; sc_enable_o=0, lock_state_o=0, resync_toggle_o=0, lost_cnt_o=0; ref_vtotal=0, ref_il=0, stable_cnt=0, timeout counter=0.
- relock_req_i passes a 2-FF synchronizer; a rising edge of the synchronized level forces HOLDOFF from any state (no toggle, no count).
- Loss conditions (ACQUIRE/LOCKED only): sync_active_i=0; timeout counter reaches FRAME_TIMEOUT.
- IDLE: sync_active_i=1 → ACQUIRE with stable_cnt=0 and ref invalid.
- ACQUIRE: on frame_change_i, first frame loads ref_vtotal/ref_il, stable_cnt=0. Later frames: match (|vtotal_i−ref_vtotal| ≤ VTOTAL_TOL, computed 12-bit unsigned, and interlace_i==ref_il) → stable_cnt+1; mismatch → reload ref, stable_cnt=0. Match with stable_cnt+1 == LOCK_FRAMES → LOCKED. Loss → IDLE (no toggle, no count).
- LOCKED: sc_enable_o=1. Matching frame keeps state (ref not updated). Mismatch or loss → HOLDOFF, toggle resync_toggle_o, increment lost_cnt_o (saturate at 255).
- HOLDOFF: sc_enable_o=0; counter runs HOLDOFF_CYCLES, then → IDLE. Events ignored except relock edge, which restarts the holdoff count.
- Timeout counter: cleared on frame_change_i and on any state entry; increments in ACQUIRE/LOCKED; saturates.
- Priority in one cycle: relock edge > sync_active_i=0 > frame_change_i > timeout.

## Timing
- All outputs registered; state, sc_enable_o, lock_state_o update one cycle after the qualifying frame_change_i/condition cycle.
- resync_toggle_o and lost_cnt_o change in the same cycle sc_enable_o falls.
- relock edge to HOLDOFF: 3 cycles (2 sync + 1 state).
- Lock latency from first frame_change_i in ACQUIRE: LOCK_FRAMES further matching frames, +1 cycle.
- Reset asserted mid-operation returns all outputs to reset values immediately (asynchronous); release synchronous to TVP_PCLK_i.

## Configuration
- CAPTURE_LOCK_STATS_EN defined: lost_cnt_o counter implemented as specified.
- Undefined: lost_cnt_o tied to 8'h00, counter logic removed; all other behaviour unchanged.

## Test plan
- Reset, sync_active_i=1, four frames vtotal=262, il=0 → ACQUIRE after 1 cycle, LOCKED and sc_enable_o=1 one cycle after fourth frame_change_i.
- LOCKED, frame with vtotal=263 (tol 1) → stays LOCKED; next frame vtotal=525 → HOLDOFF, resync_toggle_o flips, lost_cnt_o=1, IDLE after HOLDOFF_CYCLES.
- ACQUIRE, frames 262,262,300,300,300,300 → stable_cnt resets at 300, LOCKED after the sixth frame.
- LOCKED, no frame_change_i for FRAME_TIMEOUT cycles → HOLDOFF, lost_cnt_o increments; frame_change_i on the timeout cycle instead → stays LOCKED.
- sync_active_i=0 coincident with frame_change_i in LOCKED → HOLDOFF (loss wins); relock_req_i rising during LOCKED → HOLDOFF in 3 cycles, no toggle, count unchanged.
- 260 forced losses with stats enabled → lost_cnt_o=255; rebuild without CAPTURE_LOCK_STATS_EN → lost_cnt_o=0 throughout.
